key_reverse_lookup: RTL and testbench
=====================================

Name: key_reverse_lookup

Overview:
- Writable key/data table answering the reverse question of the key-selected mux: given a data value, return the key (and entry index) that owns it.
- Table of NR_KEY entries. Each entry holds a valid bit, a key and a data word.
- A search FSM scans the entries one per cycle, with valid/ready handshakes on the request and response sides.
- Used by decode/experiment logic that must map a produced value back to its selector code.

Parameters:
- NR_KEY, 4, number of table entries (>=2)
- KEY_LEN, 2, key width in bits
- DATA_LEN, 8, data width in bits
- IDX_W, $clog2(NR_KEY), derived localparam: index width

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  table write strobe
- wr_idx  input  IDX_W  entry to write; values >= NR_KEY are ignored
- wr_vld  input  1  1 = install entry, 0 = invalidate entry
- wr_key  input  KEY_LEN  key to store
- wr_data  input  DATA_LEN  data to store
- req_valid  input  1  search request present
- req_ready  output  1  FSM can accept a request
- req_data  input  DATA_LEN  value to search for
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts the result
- rsp_hit  output  1  1 = a matching valid entry was found
- rsp_key  output  KEY_LEN  key of the matching entry; 0 on miss
- rsp_idx  output  IDX_W  index of the matching entry; 0 on miss

Behaviour:
- Reset (sync, active-high):
  - All entry valid bits cleared; key/data storage is don't-care.
  - FSM goes to IDLE.
  - rsp_valid=0, rsp_hit=0, rsp_key=0, rsp_idx=0.
  - req_ready=1 from the first cycle after reset.
- Reset mid-scan or while in DONE: the operation is aborted, no response is produced, and the table is cleared.
- Write port:
  - Independent of the FSM and accepted in every state.
  - On posedge with wr_en=1 and wr_idx<NR_KEY: entry[wr_idx] gets {wr_vld, wr_key, wr_data}.
  - The write is visible to comparisons from the next cycle onward. A compare in the same cycle sees the old contents.
- FSM states: IDLE, SCAN, DONE. req_ready = (state==IDLE). rsp_valid = (state==DONE).
- IDLE: on req_valid && req_ready, latch req_data into a search register, set scan_idx=0, go to SCAN. Otherwise stay.
- SCAN: each cycle compare entry[scan_idx]; a match means (valid && data == search register).
  - Match: capture rsp_hit=1, rsp_key=entry key, rsp_idx=scan_idx; go to DONE.
  - No match and scan_idx==NR_KEY-1: capture rsp_hit=0, rsp_key=0, rsp_idx=0; go to DONE.
  - Otherwise scan_idx+1 and stay in SCAN.
- Priority: with duplicate data values, the lowest-index valid match wins.
- DONE:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready, go to IDLE. The next request can be accepted no earlier than the cycle after the handshake (no back-to-back overlap).
- Latency, counting edges after the accept edge:
  - Hit at index i: rsp_valid is high after i+1 edges.
  - Miss: rsp_valid is high after NR_KEY edges.
- req_data is sampled only at the accept edge; later changes are ignored.
- Equality compare uses the full DATA_LEN bits. Index arithmetic never wraps because the scan stops at NR_KEY-1.

Decomposition:
- Shared package/header holds:
  - FSM state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2)
  - IDX_W derivation
  - the entry layout constant PAIR_LEN = KEY_LEN + DATA_LEN (plus valid bit)
- One natural sub-module: lookup_entry_table.
  - Contains the NR_KEY entry registers, the write port and synchronous clear.
  - Exposes entry valid/key/data selected by a combinational read index.
- The top level holds the FSM, the search register and the response registers.

Test Plan:
- Reset then idle -> req_ready=1, rsp_valid=0, rsp_hit=0, rsp_key=0, rsp_idx=0; a search for 8'h00 on the empty table -> miss after 4 edges.
- Write {0:k=2'd1,d=8'hA5}, {2:k=2'd3,d=8'h3C}; search 8'h3C -> rsp_valid after 3 edges, rsp_hit=1, rsp_key=3, rsp_idx=2.
- Duplicate data: entries 1 and 3 both hold d=8'h77 with keys 2 and 0; search 8'h77 -> rsp_idx=1, rsp_key=2.
- Hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable and req_ready=0; a req_valid pulse during DONE is not accepted; rsp_ready=1 -> IDLE on the next edge.
- Invalidate entry 2 (wr_vld=0) in the same cycle the scan compares index 2 -> that compare still hits (old contents); repeat the search afterwards -> miss, rsp_hit=0.
- Assert rst during SCAN at index 1 -> no rsp_valid ever; table cleared; a subsequent search for 8'hA5 -> miss.

Source files
------------

// File: rtl/key_reverse_lookup_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_reverse_lookup_pkg
//  Description : Shared definitions for the key reverse-lookup block:
//                search FSM state encoding, index-width derivation and the
//                table entry layout helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_reverse_lookup_pkg;

    // Search FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Width of an entry index; never below one bit so ports stay legal.
    function automatic int idx_width(input int nr_key);
        return (nr_key < 2) ? 1 : $clog2(nr_key);
    endfunction

    // Stored payload of one entry: {key, data}. The valid bit is kept apart
    // because it is the only field that is cleared by reset.
    function automatic int pair_len(input int key_len, input int data_len);
        return key_len + data_len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_reverse_lookup_table.sv
`default_nettype none
// ============================================================================
//  Module      : key_reverse_lookup_table
//  Description : NR_KEY-entry key/data table with a single write port and a
//                combinational read port.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_wr_*          - write strobe/index/valid/key/data
//                i_rd_idx        - combinational read index
//                o_rd_vld/key/data - selected entry contents
//  Revision    : 1.0 - initial release
// ============================================================================
module key_reverse_lookup_table
    import key_reverse_lookup_pkg::*;
#(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 2,
    parameter int DATA_LEN = 8,
    parameter int IDX_W    = idx_width(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic                i_wr_vld,
    input  logic [KEY_LEN-1:0]  i_wr_key,
    input  logic [DATA_LEN-1:0] i_wr_data,
    input  logic [IDX_W-1:0]    i_rd_idx,
    output logic                o_rd_vld,
    output logic [KEY_LEN-1:0]  o_rd_key,
    output logic [DATA_LEN-1:0] o_rd_data
);

    localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);

    logic                r_vld  [NR_KEY];
    logic [PAIR_LEN-1:0] r_pair [NR_KEY];

    logic                w_rd_vld;
    logic [PAIR_LEN-1:0] w_rd_pair;

    // Each entry decodes its own write select. Indices >= NR_KEY match no
    // entry and are therefore dropped without extra range logic.
    for (genvar e = 0; e < NR_KEY; e++) begin : g_entry
        logic w_sel;
        assign w_sel = i_wr_en && (i_wr_idx == IDX_W'(e));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld[e] <= 1'b0;
            end else if (w_sel) begin
                r_vld[e] <= i_wr_vld;
            end
        end

        // Payload is don't-care while invalid, so it carries no reset.
        always_ff @(posedge clk) begin
            if (w_sel) begin
                r_pair[e] <= {i_wr_key, i_wr_data};
            end
        end
    end

    // Read mux written as a decode loop so an out-of-range index reads as
    // an invalid, all-zero entry instead of indexing past the array.
    always_comb begin
        w_rd_vld  = 1'b0;
        w_rd_pair = '0;
        for (int e = 0; e < NR_KEY; e++) begin
            if (i_rd_idx == IDX_W'(e)) begin
                w_rd_vld  = r_vld[e];
                w_rd_pair = r_pair[e];
            end
        end
    end

    assign o_rd_vld  = w_rd_vld;
    assign o_rd_key  = w_rd_pair[PAIR_LEN-1 -: KEY_LEN];
    assign o_rd_data = w_rd_pair[DATA_LEN-1:0];

endmodule
`default_nettype wire

// File: rtl/key_reverse_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : key_reverse_lookup
//  Description : Reverse lookup of a writable key/data table: given a data
//                value, return the key and index of the lowest-index valid
//                entry holding it. Entries are scanned one per cycle.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                i_wr_*                - table write port (any state)
//                i_req_valid/o_req_ready/i_req_data - search request
//                o_rsp_valid/i_rsp_ready           - response handshake
//                o_rsp_hit/o_rsp_key/o_rsp_idx     - search result
//  Revision    : 1.0 - initial release
// ============================================================================
module key_reverse_lookup
    import key_reverse_lookup_pkg::*;
#(
    parameter  int NR_KEY   = 4,
    parameter  int KEY_LEN  = 2,
    parameter  int DATA_LEN = 8,
    localparam int IDX_W    = idx_width(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic                i_wr_vld,
    input  logic [KEY_LEN-1:0]  i_wr_key,
    input  logic [DATA_LEN-1:0] i_wr_data,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic [DATA_LEN-1:0] i_req_data,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic                o_rsp_hit,
    output logic [KEY_LEN-1:0]  o_rsp_key,
    output logic [IDX_W-1:0]    o_rsp_idx
);

    logic [1:0]          r_state;
    logic [DATA_LEN-1:0] r_search;
    logic [IDX_W-1:0]    r_scan_idx;
    logic                r_rsp_hit;
    logic [KEY_LEN-1:0]  r_rsp_key;
    logic [IDX_W-1:0]    r_rsp_idx;

    logic                w_rd_vld;
    logic [KEY_LEN-1:0]  w_rd_key;
    logic [DATA_LEN-1:0] w_rd_data;
    logic                w_match;
    logic                w_last;

    key_reverse_lookup_table #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN),
        .IDX_W    (IDX_W)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (i_wr_en),
        .i_wr_idx  (i_wr_idx),
        .i_wr_vld  (i_wr_vld),
        .i_wr_key  (i_wr_key),
        .i_wr_data (i_wr_data),
        .i_rd_idx  (r_scan_idx),
        .o_rd_vld  (w_rd_vld),
        .o_rd_key  (w_rd_key),
        .o_rd_data (w_rd_data)
    );

    // The compare reads the table registers directly, so a write landing on
    // the same edge is not seen until the following cycle.
    assign w_match = w_rd_vld && (w_rd_data == r_search);
    assign w_last  = (r_scan_idx == IDX_W'(NR_KEY - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_search   <= '0;
            r_scan_idx <= '0;
            r_rsp_hit  <= 1'b0;
            r_rsp_key  <= '0;
            r_rsp_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_search   <= i_req_data;
                        r_scan_idx <= '0;
                        r_state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Ascending scan that stops at the first match gives
                    // lowest-index priority among duplicate data values.
                    if (w_match) begin
                        r_rsp_hit <= 1'b1;
                        r_rsp_key <= w_rd_key;
                        r_rsp_idx <= r_scan_idx;
                        r_state   <= ST_DONE;
                    end else if (w_last) begin
                        r_rsp_hit <= 1'b0;
                        r_rsp_key <= '0;
                        r_rsp_idx <= '0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (i_rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_rsp_valid = (r_state == ST_DONE);
    assign o_rsp_hit   = r_rsp_hit;
    assign o_rsp_key   = r_rsp_key;
    assign o_rsp_idx   = r_rsp_idx;

endmodule
`default_nettype wire

// File: tb/tb_key_reverse_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_reverse_lookup
//  Description : Self-checking bench for key_reverse_lookup. Stimulus pushes
//                expected responses into a queue; a monitor pops and compares
//                on every response handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_reverse_lookup;

    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 2;
    localparam int DATA_LEN = 8;
    localparam int IDX_W    = 2;

    typedef struct packed {
        logic               hit;
        logic [KEY_LEN-1:0] key;
        logic [IDX_W-1:0]   idx;
    } exp_t;

    logic                clk;
    logic                rst;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic                wr_vld;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                req_valid;
    logic                req_ready;
    logic [DATA_LEN-1:0] req_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_hit;
    logic [KEY_LEN-1:0]  rsp_key;
    logic [IDX_W-1:0]    rsp_idx;

    int   total;
    int   bad;
    exp_t sb[$];
    exp_t mon_e;

    key_reverse_lookup #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (wr_en),
        .i_wr_idx    (wr_idx),
        .i_wr_vld    (wr_vld),
        .i_wr_key    (wr_key),
        .i_wr_data   (wr_data),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_data  (req_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_hit   (rsp_hit),
        .o_rsp_key   (rsp_key),
        .o_rsp_idx   (rsp_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every accepted response against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got hit=%0d key=%0d idx=%0d expected=none",
                         rsp_hit, rsp_key, rsp_idx);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_hit", 32'(rsp_hit), 32'(mon_e.hit));
                chk("rsp_key", 32'(rsp_key), 32'(mon_e.key));
                chk("rsp_idx", 32'(rsp_idx), 32'(mon_e.idx));
            end
        end
    end

    task automatic write_entry(input int idx, input bit vld, input int key, input int data);
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(idx);
        wr_vld  = vld;
        wr_key  = KEY_LEN'(key);
        wr_data = DATA_LEN'(data);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Issue one search; optionally invalidate entry inv_idx so that the
    // write lands on edge inv_edge after accept, and hold rsp_ready low for
    // 'hold' cycles with a stray req_valid pulse during the hold.
    task automatic do_search(input int d, input bit hit, input int key, input int idx,
                             input int lat, input int hold, input int inv_edge, input int inv_idx);
        int   n;
        exp_t e;
        chk("req_ready_pre", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_data  = DATA_LEN'(d);
        e.hit = hit;
        e.key = KEY_LEN'(key);
        e.idx = IDX_W'(idx);
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = DATA_LEN'($urandom);
        n = 0;
        while (1) begin
            if (inv_edge > 0 && n == inv_edge - 1) begin
                wr_en   = 1'b1;
                wr_idx  = IDX_W'(inv_idx);
                wr_vld  = 1'b0;
                wr_key  = '0;
                wr_data = '0;
            end
            @(posedge clk);
            #1;
            wr_en = 1'b0;
            n++;
            if (rsp_valid || n >= 20) break;
        end
        chk("latency", 32'(n), 32'(lat));
        for (int h = 0; h < hold; h++) begin
            req_valid = (h == 1);
            req_data  = DATA_LEN'(d);
            @(posedge clk);
            #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_rsp_hit",   32'(rsp_hit),   32'(hit));
            chk("hold_rsp_key",   32'(rsp_key),   32'(key));
            chk("hold_rsp_idx",   32'(rsp_idx),   32'(idx));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int cnt;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_vld    = 1'b0;
        wr_key    = '0;
        wr_data   = '0;
        req_valid = 1'b0;
        req_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_hit",   32'(rsp_hit),   32'd0);
        chk("rst_rsp_key",   32'(rsp_key),   32'd0);
        chk("rst_rsp_idx",   32'(rsp_idx),   32'd0);
        @(posedge clk);
        #1;

        // Empty table: miss after NR_KEY edges
        do_search(8'h00, 1'b0, 0, 0, 4, 0, 0, 0);

        // Basic hits
        write_entry(0, 1'b1, 1, 8'hA5);
        write_entry(2, 1'b1, 3, 8'h3C);
        do_search(8'h3C, 1'b1, 3, 2, 3, 0, 0, 0);
        do_search(8'hA5, 1'b1, 1, 0, 1, 0, 0, 0);
        do_search(8'h5A, 1'b0, 0, 0, 4, 0, 0, 0);

        // Duplicates: lowest index wins; hold response for 5 cycles
        write_entry(1, 1'b1, 2, 8'h77);
        write_entry(3, 1'b1, 0, 8'h77);
        do_search(8'h77, 1'b1, 2, 1, 2, 5, 0, 0);

        // Invalidate entry 2 on the very edge that compares it: old contents win
        do_search(8'h3C, 1'b1, 3, 2, 3, 0, 3, 2);
        do_search(8'h3C, 1'b0, 0, 0, 4, 0, 0, 0);

        // Reset while the scan sits at index 1 (search would hit at index 1)
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_data  = 8'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) cnt++;
        end
        chk("abort_no_rsp",    32'(cnt),       32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_hit",   32'(rsp_hit),   32'd0);
        do_search(8'hA5, 1'b0, 0, 0, 4, 0, 0, 0);
        do_search(8'h77, 1'b0, 0, 0, 4, 0, 0, 0);

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
